// File: rtl/clock_pkg.sv
// Shared clock/time-setter definitions: FSM states, field codes,
// time word layout and BCD / wrap-around helpers.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_HR,
    ST_SET_MIN,
    ST_SET_SEC,
    ST_COMMIT
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HR   = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam int unsigned HOUR_MAX   = 23;
  localparam int unsigned MINSEC_MAX = 59;

  // time word: {hour[4:0], min[5:0], sec[5:0]}
  localparam int unsigned TIME_W  = 17;
  localparam int unsigned HR_W    = 5;
  localparam int unsigned MS_W    = 6;
  localparam int unsigned SEC_LSB = 0;
  localparam int unsigned MIN_LSB = 6;
  localparam int unsigned HR_LSB  = 12;

  // Bad digits map to an out-of-range value so the
  // range check below rejects them as well.
  function automatic logic [6:0] bcd_raw(
    input logic [3:0] tens,
    input logic [3:0] ones
  );
    if (tens > 4'd9 || ones > 4'd9) return 7'h7f;
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

  function automatic logic [HR_W-1:0] bcd_hour(
    input logic [3:0] tens,
    input logic [3:0] ones
  );
    logic [6:0] v;
    v = bcd_raw(tens, ones);
    if (v > 7'(HOUR_MAX)) return '0;
    return v[HR_W-1:0];
  endfunction

  function automatic logic [MS_W-1:0] bcd_minsec(
    input logic [3:0] tens,
    input logic [3:0] ones
  );
    logic [6:0] v;
    v = bcd_raw(tens, ones);
    if (v > 7'(MINSEC_MAX)) return '0;
    return v[MS_W-1:0];
  endfunction

  // inc and dec together cancel out
  function automatic logic [HR_W-1:0] step_hr(
    input logic [HR_W-1:0] v,
    input logic            inc,
    input logic            dec
  );
    if (inc && !dec)
      return (v == HR_W'(HOUR_MAX)) ? '0 : v + HR_W'(1);
    if (dec && !inc)
      return (v == '0) ? HR_W'(HOUR_MAX) : v - HR_W'(1);
    return v;
  endfunction

  function automatic logic [MS_W-1:0] step_ms(
    input logic [MS_W-1:0] v,
    input logic            inc,
    input logic            dec
  );
    if (inc && !dec)
      return (v == MS_W'(MINSEC_MAX)) ? '0 : v + MS_W'(1);
    if (dec && !inc)
      return (v == '0) ? MS_W'(MINSEC_MAX) : v - MS_W'(1);
    return v;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Button conditioner: 2-FF sync, debounce, rising-edge pulse.
// Ports: clk, rst_n, btn (raw async) -> pulse (1 cycle per press).
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // level only follows sync2 after it has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles; a press is the
  // accepted 0->1 change of level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        pulse <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/time_setter.sv
// Time-entry controller: edits h/m/s from buttons, commits a packed
// word with an overwrite strobe. Ports: buttons, BCD time in,
// time_set/time_ow to the clock, editing/edit_field for display.
module time_setter
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned OW_CYCLES       = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic              btn_cancel,
  input  logic [3:0]        hr_10s,
  input  logic [3:0]        hr_1s,
  input  logic [3:0]        min_10s,
  input  logic [3:0]        min_1s,
  input  logic [3:0]        sec_10s,
  input  logic [3:0]        sec_1s,
  output logic [TIME_W-1:0] time_set,
  output logic              time_ow,
  output logic              editing,
  output logic [1:0]        edit_field
);

  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned OWW = $clog2(OW_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [OWW-1:0] OW_LAST  = OWW'(OW_CYCLES - 1);

  logic mode_p;
  logic inc_p;
  logic dec_p;
  logic cancel_p;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_mode),
    .pulse (mode_p)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_inc),
    .pulse (inc_p)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_dec),
    .pulse (dec_p)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_cancel),
    .pulse (cancel_p)
  );

  state_t          state;
  logic [HR_W-1:0] hr;
  logic [MS_W-1:0] mn;
  logic [MS_W-1:0] sc;
  logic [TW-1:0]   tmo;
  logic [OWW-1:0]  owc;

  logic            any_p;
  logic            tmo_hit;
  logic [HR_W-1:0] cap_hr;
  logic [MS_W-1:0] cap_mn;
  logic [MS_W-1:0] cap_sc;
  logic [HR_W-1:0] hr_step;
  logic [MS_W-1:0] mn_step;
  logic [MS_W-1:0] sc_step;

  assign any_p   = mode_p | inc_p | dec_p | cancel_p;
  assign tmo_hit = (tmo == TMO_LAST) && !any_p;

  assign cap_hr = bcd_hour(hr_10s, hr_1s);
  assign cap_mn = bcd_minsec(min_10s, min_1s);
  assign cap_sc = bcd_minsec(sec_10s, sec_1s);

  assign hr_step = step_hr(hr, inc_p, dec_p);
  assign mn_step = step_ms(mn, inc_p, dec_p);
  assign sc_step = step_ms(sc, inc_p, dec_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hr         <= '0;
      mn         <= '0;
      sc         <= '0;
      tmo        <= '0;
      owc        <= '0;
      time_set   <= '0;
      time_ow    <= 1'b0;
      editing    <= 1'b0;
      edit_field <= FIELD_NONE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (mode_p) begin
            hr         <= cap_hr;
            mn         <= cap_mn;
            sc         <= cap_sc;
            tmo        <= '0;
            state      <= ST_SET_HR;
            editing    <= 1'b1;
            edit_field <= FIELD_HR;
          end
        end

        ST_SET_HR, ST_SET_MIN, ST_SET_SEC: begin
          // a timeout behaves exactly like cancel
          if (cancel_p || tmo_hit) begin
            state      <= ST_IDLE;
            editing    <= 1'b0;
            edit_field <= FIELD_NONE;
          end else if (mode_p) begin
            tmo <= '0;
            case (state)
              ST_SET_HR: begin
                state      <= ST_SET_MIN;
                edit_field <= FIELD_MIN;
              end
              ST_SET_MIN: begin
                state      <= ST_SET_SEC;
                edit_field <= FIELD_SEC;
              end
              default: begin
                state      <= ST_COMMIT;
                editing    <= 1'b0;
                edit_field <= FIELD_NONE;
                time_set   <= {hr, mn, sc};
                time_ow    <= 1'b1;
                owc        <= '0;
              end
            endcase
          end else begin
            tmo <= any_p ? '0 : tmo + TW'(1);
            case (state)
              ST_SET_HR:  hr <= hr_step;
              ST_SET_MIN: mn <= mn_step;
              default:    sc <= sc_step;
            endcase
          end
        end

        ST_COMMIT: begin
          if (owc == OW_LAST) begin
            time_ow <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            owc <= owc + OWW'(1);
          end
        end

        default: begin
          state      <= ST_IDLE;
          time_ow    <= 1'b0;
          editing    <= 1'b0;
          edit_field <= FIELD_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_setter.sv
// Scoreboard bench for time_setter: random and directed edit sessions
// against a plain-arithmetic model; a monitor checks each commit.
module tb_time_setter;

  localparam int D  = 16;
  localparam int OW = 4;

  localparam logic [3:0] M = 4'b0001;
  localparam logic [3:0] I = 4'b0010;
  localparam logic [3:0] R = 4'b0100;
  localparam logic [3:0] C = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  btn = '0;
  logic [3:0]  h10 = '0, h1 = '0, m10 = '0, m1 = '0, s10 = '0, s1 = '0;
  logic [16:0] time_set;
  logic        time_ow;
  logic        editing;
  logic [1:0]  edit_field;

  always #5 clk = ~clk;

  time_setter #(
    .DEBOUNCE_CYCLES (D),
    .OW_CYCLES       (OW),
    .TIMEOUT_CYCLES  (1024)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_mode   (btn[0]),
    .btn_inc    (btn[1]),
    .btn_dec    (btn[2]),
    .btn_cancel (btn[3]),
    .hr_10s     (h10),
    .hr_1s      (h1),
    .min_10s    (m10),
    .min_1s     (m1),
    .sec_10s    (s10),
    .sec_1s     (s1),
    .time_set   (time_set),
    .time_ow    (time_ow),
    .editing    (editing),
    .edit_field (edit_field)
  );

  int n_checks = 0;
  int n_err = 0;
  int q[$];

  // model: field 0 = idle, 1..3 = hour/min/sec
  int m_h, m_m, m_s, m_field, m_last;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int word_of(int h, int mi, int s);
    return h * 4096 + mi * 64 + s;
  endfunction

  function automatic int cap(int t, int o, int mx);
    if (t > 9 || o > 9 || t * 10 + o > mx) return 0;
    return t * 10 + o;
  endfunction

  task automatic set_raw(int a, int b, int c, int d, int e, int f);
    h10 = 4'(a); h1 = 4'(b);
    m10 = 4'(c); m1 = 4'(d);
    s10 = 4'(e); s1 = 4'(f);
  endtask

  task automatic set_bcd(int h, int mi, int s);
    set_raw(h / 10, h % 10, mi / 10, mi % 10, s / 10, s % 10);
  endtask

  task automatic model(logic [3:0] mask);
    if (m_field == 0) begin
      if (mask[0]) begin
        m_h = cap(h10, h1, 23);
        m_m = cap(m10, m1, 59);
        m_s = cap(s10, s1, 59);
        m_field = 1;
      end
    end else if (mask[3]) begin
      m_field = 0;
    end else if (mask[0]) begin
      if (m_field == 3) begin
        m_last = word_of(m_h, m_m, m_s);
        q.push_back(m_last);
        m_field = 0;
      end else begin
        m_field++;
      end
    end else if (mask[1] != mask[2]) begin
      int d;
      d = mask[1] ? 1 : -1;
      case (m_field)
        1: m_h = (m_h + d + 24) % 24;
        2: m_m = (m_m + d + 60) % 60;
        default: m_s = (m_s + d + 60) % 60;
      endcase
    end
  endtask

  // holds shorter than the debounce window are glitches
  task automatic act(logic [3:0] mask, int hold);
    if (hold >= D + 4) model(mask);
    btn = mask;
    tick(hold);
    btn = '0;
    tick(25);
    check("editing", int'(editing), int'(m_field != 0));
    check("edit_field", int'(edit_field), m_field);
  endtask

  // commit monitor
  int  exp_word = -1;
  int  ow_len = 0;
  bit  prev_ow = 1'b0;
  bit  ow_abort = 1'b0;

  always @(negedge clk) begin
    if (time_ow && !prev_ow) begin
      ow_len = 1;
      ow_abort = 1'b0;
      if (q.size() == 0) begin
        exp_word = -1;
        check("unexpected_commit", 1, 0);
      end else begin
        exp_word = q.pop_front();
        check("commit_word", int'(time_set), exp_word);
      end
    end else if (time_ow) begin
      ow_len++;
      check("word_stable", int'(time_set), exp_word);
    end
    if (prev_ow && !rst_n) ow_abort = 1'b1;
    if (!time_ow && prev_ow && !ow_abort)
      check("ow_len", ow_len, OW);
    prev_ow = time_ow;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit done;
    m_h = 0; m_m = 0; m_s = 0; m_field = 0; m_last = 0;

    // reset with buttons mashed
    set_bcd(0, 0, 0);
    btn = 4'hf;
    tick(3);
    check("rst_time_set", int'(time_set), 0);
    check("rst_time_ow", int'(time_ow), 0);
    check("rst_editing", int'(editing), 0);
    check("rst_field", int'(edit_field), 0);
    btn = '0;
    tick(2);
    rst_n = 1'b1;
    tick(10000);
    check("idle_ow", int'(time_ow), 0);
    check("idle_editing", int'(editing), 0);

    // full edit 12:34:56 -> 14:33:56
    set_bcd(12, 34, 56);
    act(M, 30);
    act(I, 30);
    act(I, 30);
    act(M, 30);
    act(R, 30);
    act(M, 30);
    act(M, 30);
    check("full_edit", int'(time_set), word_of(14, 33, 56));

    // wrap-around
    set_bcd(23, 59, 0);
    act(M, 25);
    act(I, 25);
    act(M, 25);
    act(I, 25);
    act(M, 25);
    act(R, 25);
    act(M, 25);
    check("wrap_edit", int'(time_set), word_of(0, 0, 59));

    // cancel in SET_MIN
    set_bcd(5, 6, 7);
    act(M, 25);
    act(M, 25);
    act(I, 25);
    act(C, 25);
    check("cancel_hold", int'(time_set), m_last);

    // timeout in SET_HR
    act(M, 25);
    tick(900);
    check("tmo_before", int'(editing), 1);
    tick(200);
    m_field = 0;
    check("tmo_after", int'(editing), 0);
    check("tmo_field", int'(edit_field), 0);
    check("tmo_hold", int'(time_set), m_last);

    // glitch, long hold, inc+dec together
    set_bcd(10, 20, 30);
    act(M, 25);
    act(I, 10);
    act(I, 500);
    act(I | R, 30);
    act(M, 25);
    act(M, 25);
    act(M, 25);
    check("debounce_edit", int'(time_set), word_of(11, 20, 30));

    // mode and cancel together
    act(M, 25);
    act(M | C, 25);

    // invalid capture: 27:59:60
    set_raw(2, 7, 5, 9, 6, 0);
    act(M, 25);
    act(M, 25);
    act(M, 25);
    act(M, 25);
    check("invalid_cap", int'(time_set), word_of(0, 59, 0));

    // reset during the 2nd time_ow cycle
    set_bcd(8, 9, 10);
    act(M, 25);
    act(M, 25);
    act(M, 25);
    q.push_back(word_of(8, 9, 10));
    btn = M;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      tick(1);
      if (time_ow) done = 1'b1;
    end
    check("ow_seen", int'(done), 1);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("rst_ow_drop", int'(time_ow), 0);
    check("rst_mid_set", int'(time_set), 0);
    btn = '0;
    tick(3);
    rst_n = 1'b1;
    m_field = 0;
    m_last = 0;
    tick(30);
    check("rst_mid_idle", int'(editing), 0);
    check("rst_mid_field", int'(edit_field), 0);

    // random sessions
    for (int n = 0; n < 25; n++) begin
      bit stop;
      if ($urandom_range(0, 9) == 0)
        set_raw($urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 15));
      else
        set_bcd($urandom_range(0, 23), $urandom_range(0, 59),
                $urandom_range(0, 59));
      act(M, $urandom_range(20, 40));
      // clock keeps ticking underneath the edit
      set_bcd($urandom_range(0, 23), $urandom_range(0, 59),
              $urandom_range(0, 59));
      stop = 1'b0;
      for (int f = 0; f < 3 && !stop; f++) begin
        int k;
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) begin
          int r;
          r = $urandom_range(0, 9);
          act(r < 5 ? I : (r < 9 ? R : (I | R)),
              $urandom_range(20, 40));
        end
        if ($urandom_range(0, 9) == 0) begin
          act(C, 25);
          stop = 1'b1;
        end else begin
          act(M, $urandom_range(20, 40));
        end
      end
      check("rand_word", int'(time_set), m_last);
    end

    tick(20);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/time_setter.md
# time_setter

User-facing time-entry controller that drives the overwrite side of the digital clock, i.e. the writer for the clock's `time_in`/`time_ow` port pair. It reads the clock's BCD digit outputs to seed an edit session, lets the user step hours/minutes/seconds with buttons, and commits the edited value as a packed 17-bit word plus an overwrite pulse. It runs on the fast system clock, alongside the 1 Hz clock domain.

## Interface
- `DEBOUNCE_CYCLES`, 16: cycles a synchronized button level must hold before it is accepted.
- `OW_CYCLES`, 4: length of the `time_ow` pulse in cycles.
- `TIMEOUT_CYCLES`, 1024: idle cycles in an edit state before the session auto-cancels.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_mode`, `btn_inc`, `btn_dec`, `btn_cancel` in 1 each: raw, asynchronous, active-high buttons.
- `hr_10s`, `hr_1s`, `min_10s`, `min_1s`, `sec_10s`, `sec_1s` in 4 each: current time from the clock, BCD.
- `time_set` out 17: `{hour[4:0], min[5:0], sec[5:0]}`, binary, to the clock `time_in`.
- `time_ow` out 1: overwrite strobe, active-high, to the clock `time_ow`.
- `editing` out 1: high in any SET state.
- `edit_field` out 2: field being edited. 0 = none, 1 = hour, 2 = min, 3 = sec. Used for display blink.

## Operation
- **Button conditioning:** each button goes through a 2-FF synchronizer, then a debounce counter, then a rising-edge detect. The result is a 1-cycle `*_p` pulse per accepted press. Holding a button produces exactly one pulse.
- **States:** IDLE, SET_HR, SET_MIN, SET_SEC, COMMIT.
- **IDLE**
  - On `mode_p`, capture the BCD inputs into the edit registers: hour = hr_10s·10+hr_1s, and the same for min and sec.
  - Go to SET_HR.
  - Any digit > 9, hour > 23 or min/sec > 59 captures that field as 0.
- **SET_HR / SET_MIN / SET_SEC**
  - `inc_p` adds 1 to the active field and `dec_p` subtracts 1.
  - Wrap-around: hour 23→0 on inc and 0→23 on dec. Min and sec wrap 59→0 and 0→59.
  - `mode_p` advances HR→MIN→SEC→COMMIT.
- **Priority within one cycle:** `cancel_p` > `mode_p` > `inc_p`/`dec_p`. If `inc_p` and `dec_p` are both high, the field is unchanged.
- **Cancel:** `cancel_p` in any SET state returns to IDLE. `time_set` and `time_ow` are untouched.
- **Timeout:**
  - The counter resets on any button pulse and on entering a SET state.
  - Reaching `TIMEOUT_CYCLES` in a SET state acts as cancel.
- **COMMIT**
  - `time_set` is loaded from the edit registers on the entry cycle.
  - `time_ow` goes high for exactly `OW_CYCLES` cycles, then the block returns to IDLE.
  - All buttons are ignored in COMMIT.
- **`time_set` outside COMMIT:** holds its last committed value between commits.
- **Edit register widths:** 5/6/6 bits. Arithmetic is compare-then-wrap and never relies on modulo overflow.

## Timing
- **Reset values** (while `rst_n` is low, async):
  - state IDLE, `time_set` = 0, `time_ow` = 0, `editing` = 0, `edit_field` = 0.
  - Edit registers, debounce counters, synchronizers and timeout counter are all 0.
- **Press latency:** a press stable from cycle t produces its pulse at t+2+`DEBOUNCE_CYCLES`.
- **State update:** changes are registered and visible the cycle after the pulse.
- **Commit latency:**
  - `mode_p` in SET_SEC at cycle n puts the block in COMMIT at n+1.
  - `time_set` is valid and `time_ow` = 1 from n+1 through n+`OW_CYCLES`.
  - State is IDLE at n+`OW_CYCLES`+1.
- **Setup guarantee:** `time_set` is stable at least one cycle before `time_ow` falls, and stays stable after.
- **Reset mid-commit:** `time_ow` drops immediately. No partial word is required to be held.
- **Capture:** uses the BCD value sampled in the `mode_p` cycle. A 1 Hz tick during an edit does not affect the edit registers.

## Structure
- Shared package `clock_pkg`:
  - state enum.
  - field codes (`FIELD_NONE`/`HR`/`MIN`/`SEC`).
  - `HOUR_MAX` = 23, `MINSEC_MAX` = 59.
  - `TIME_W` = 17 and the field slice positions, so the clock and the setter share one definition.
- Sub-module `btn_conditioner`: synchronizer, debounce and edge-detect, parameterized by `DEBOUNCE_CYCLES`. Instantiated four times.
- Top level: FSM, edit registers, BCD-to-binary conversion, timeout counter and `time_ow` pulse counter.

## Test plan
- **Reset:** hold `rst_n` = 0 mid-stream → all outputs 0. Release with no buttons → `time_ow` stays 0 for 10000 cycles.
- **Full edit:** BCD 12:34:56, press mode, then inc on hour twice, mode, dec on min once, mode, mode → `time_set` = {14, 33, 56}, `time_ow` high exactly 4 cycles.
- **Wrap-around:**
  - Capture 23:59:00; inc hour → 0.
  - mode; inc min → 0.
  - mode; dec sec → 59.
  - Commit → {0, 0, 59}.
- **Cancel and timeout:**
  - Cancel in SET_MIN → IDLE, `time_ow` never asserts, `time_set` unchanged.
  - No buttons for 1024 cycles in SET_HR → IDLE, no commit.
- **Debounce and priority:**
  - A 10-cycle glitch on inc → no change.
  - A 500-cycle hold → exactly one increment.
  - inc and dec accepted in the same cycle → field unchanged.
  - mode and cancel together → IDLE.
- **Invalid capture and reset mid-commit:**
  - BCD hours 2,7 → hour captured 0.
  - `rst_n` low in the 2nd `time_ow` cycle → `time_ow` = 0 immediately, state IDLE after release.
